// File: rtl/arm_shift_pkg.sv
// ---------------------------------------------------------------------------
// arm_shift_pkg
// Shared definitions for the pipelined ARM shifter-operand unit:
//   - 3-bit shift operation encodings (SHOP_*)
//   - shift_log2(): constant-evaluable ceil(log2) used to size rotate amounts
// ---------------------------------------------------------------------------
package arm_shift_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] SHOP_LSL = 3'b000;
  localparam logic [OP_W-1:0] SHOP_LSR = 3'b001;
  localparam logic [OP_W-1:0] SHOP_ASR = 3'b010;
  localparam logic [OP_W-1:0] SHOP_ROR = 3'b011;
  localparam logic [OP_W-1:0] SHOP_RRX = 3'b100;

  // Smallest r with (1 << r) >= v; used at elaboration time only.
  function automatic int shift_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_rotr_core.sv
// ---------------------------------------------------------------------------
// shift_rotr_core
// Combinational log-depth rotate-right. Stage i rotates by 2**i when amt_i[i]
// is set, so the depth is SW mux levels regardless of W.
// Ports:
//   data_i  [W-1:0]   value to rotate
//   amt_i   [SW-1:0]  rotate-right amount (modulo W)
//   data_o  [W-1:0]   rotated value
// ---------------------------------------------------------------------------
module shift_rotr_core
  import arm_shift_pkg::*;
#(
  parameter int W  = 32,
  parameter int SW = shift_log2(W)
) (
  input  logic [W-1:0]  data_i,
  input  logic [SW-1:0] amt_i,
  output logic [W-1:0]  data_o
);

  logic [W-1:0] stg;

  always_comb begin
    stg = data_i;
    for (int i = 0; i < SW; i++) begin
      if (amt_i[i]) begin
        stg = (stg >> (1 << i)) | (stg << (W - (1 << i)));
      end
    end
  end

  assign data_o = stg;

endmodule

// File: rtl/arm_shift_unit_pipe.sv
// ---------------------------------------------------------------------------
// arm_shift_unit_pipe
// Two-stage pipelined ARM shifter operand (LSL/LSR/ASR/ROR/RRX) with ARM
// register-specified carry-out, valid/ready handshake and tag passthrough.
//   S1: registers operand, carry, tag, op and amount classification
//       (zero / equal-to-width / greater-than-width / amount mod width).
//   S2: single shared rotator plus mask / sign-fill / carry selection.
// Ports:
//   clk, rst                synchronous active-high reset
//   in_valid / in_ready     input handshake
//   in_data [DATA_W]        operand
//   in_amt  [AMT_W]         shift amount
//   in_op   [3]             SHOP_* encoding, others pass data through
//   in_cin                  current C flag
//   in_tag  [TAG_W]         sideband tag
//   out_valid / out_ready   output handshake
//   out_data [DATA_W]       result
//   out_cout                shifter carry-out
//   out_tag  [TAG_W]        tag of this result
// ---------------------------------------------------------------------------
module arm_shift_unit_pipe
  import arm_shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_cin,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_cout,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int LW = shift_log2(DATA_W);
  localparam logic [DATA_W-1:0] ONES = '1;

  // -------------------------------------------------------------------------
  // Handshake chain
  // -------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_ready, s2_ready;
  logic s1_load, s2_load;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign s1_load  = s1_ready && in_valid;
  assign s2_load  = s2_ready && s1_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_ready) s1_valid_d = in_valid;
    if (s2_ready) s2_valid_d = s1_valid_q;
  end

  // -------------------------------------------------------------------------
  // S1: operand capture and amount classification
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_cin_q;
  logic [TAG_W-1:0]  s1_tag_q;
  logic [OP_W-1:0]   s1_op_q;
  logic              s1_zero_q, s1_big_q, s1_eq_q;
  logic [LW-1:0]     s1_m_q;

  logic              amt_zero, amt_big, amt_eq;

  assign amt_zero = (in_amt == '0);
  assign amt_big  = (int'(in_amt) > DATA_W);
  assign amt_eq   = (int'(in_amt) == DATA_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_cin_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_op_q    <= '0;
      s1_zero_q  <= 1'b0;
      s1_big_q   <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_m_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_data_q <= in_data;
        s1_cin_q  <= in_cin;
        s1_tag_q  <= in_tag;
        s1_op_q   <= in_op;
        s1_zero_q <= amt_zero;
        s1_big_q  <= amt_big;
        s1_eq_q   <= amt_eq;
        s1_m_q    <= in_amt[LW-1:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // S2 datapath: one rotator shared by every op
  // -------------------------------------------------------------------------
  logic [LW-1:0]     rot_amt;
  logic [DATA_W-1:0] rot;
  logic [DATA_W-1:0] lsr_mask, lsl_mask;
  logic              sign;

  // Left shifts reuse the right rotator: rotr by (W - m) mod W == rotl by m.
  always_comb begin
    rot_amt = '0;
    case (s1_op_q)
      SHOP_LSL: rot_amt = LW'(0) - s1_m_q;
      SHOP_LSR,
      SHOP_ASR,
      SHOP_ROR: rot_amt = s1_m_q;
      SHOP_RRX: rot_amt = LW'(1);
      default:  rot_amt = '0;
    endcase
  end

  shift_rotr_core #(
    .W  (DATA_W),
    .SW (LW)
  ) u_rotr (
    .data_i (s1_data_q),
    .amt_i  (rot_amt),
    .data_o (rot)
  );

  assign lsr_mask = ONES >> s1_m_q;
  assign lsl_mask = ONES << s1_m_q;
  assign sign     = s1_data_q[DATA_W-1];

  logic [DATA_W-1:0] s2_data_d;
  logic              s2_cout_d;

  // In the 1 <= n < W range the amount equals m, so the last bit shifted out
  // always lands at a fixed position of the rotated word: bit 0 for LSL,
  // the MSB for LSR/ASR/ROR/RRX.
  always_comb begin
    s2_data_d = s1_data_q;
    s2_cout_d = s1_cin_q;
    case (s1_op_q)
      SHOP_LSL: begin
        if (s1_eq_q) begin
          s2_data_d = '0;
          s2_cout_d = s1_data_q[0];
        end else if (s1_big_q) begin
          s2_data_d = '0;
          s2_cout_d = 1'b0;
        end else if (!s1_zero_q) begin
          s2_data_d = rot & lsl_mask;
          s2_cout_d = rot[0];
        end
      end
      SHOP_LSR: begin
        if (s1_eq_q) begin
          s2_data_d = '0;
          s2_cout_d = sign;
        end else if (s1_big_q) begin
          s2_data_d = '0;
          s2_cout_d = 1'b0;
        end else if (!s1_zero_q) begin
          s2_data_d = rot & lsr_mask;
          s2_cout_d = rot[DATA_W-1];
        end
      end
      SHOP_ASR: begin
        if (s1_eq_q || s1_big_q) begin
          s2_data_d = {DATA_W{sign}};
          s2_cout_d = sign;
        end else if (!s1_zero_q) begin
          s2_data_d = (rot & lsr_mask) | (~lsr_mask & {DATA_W{sign}});
          s2_cout_d = rot[DATA_W-1];
        end
      end
      SHOP_ROR: begin
        // m == 0 with a non-zero amount rotates to the identity; the MSB
        // then becomes the carry, which rot[W-1] already provides.
        if (!s1_zero_q) begin
          s2_data_d = rot;
          s2_cout_d = rot[DATA_W-1];
        end
      end
      SHOP_RRX: begin
        s2_data_d = {s1_cin_q, rot[DATA_W-2:0]};
        s2_cout_d = rot[DATA_W-1];
      end
      default: begin
        s2_data_d = s1_data_q;
        s2_cout_d = s1_cin_q;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // S2 registers: only reload on a real transfer so stalled outputs hold
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] s2_data_q;
  logic              s2_cout_q;
  logic [TAG_W-1:0]  s2_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_cout_q  <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_data_q <= s2_data_d;
        s2_cout_q <= s2_cout_d;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign in_ready  = s1_ready;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_cout  = s2_cout_q;
  assign out_tag   = s2_tag_q;

endmodule
